// File: rtl/spawn_scheduler.sv
// -----------------------------------------------------------------------------
// spawn_scheduler
//
// Frame-driven controller for the falling-object slots. It keeps a y position
// per slot, advances every slot once per accepted frame tick, then walks the
// slots in ascending order and respawns any slot that has reached the bottom.
// Each respawn is a single-cycle one-hot load_x strobe with a bounded random
// column index on rand_int, one slot per cycle.
//
// Optional build macro: SPAWN_COUNT_EN
//   defined   : spawn_count is a 16-bit wrapping count of LOAD cycles.
//   undefined : no counter register exists; spawn_count reads 16'd0.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   enable       in   game running; frame ticks ignored while low
//   frame_tick   in   one-cycle pulse per frame
//   load_x       out  one-hot respawn strobe (NUM_OBJ bits), zero when idle
//   rand_int     out  column index 0..14, valid while load_x != 0
//   y_all        out  packed y positions, slot i at [8i+7:8i]
//   busy         out  high whenever the sequencer is not idle
//   overrun      out  sticky: a frame tick arrived while busy
//   spawn_count  out  respawn counter (see macro above)
// -----------------------------------------------------------------------------
module spawn_scheduler #(
  parameter int         NUM_OBJ   = 10,
  parameter int         Y_MAX     = 120,
  parameter int         Y_STEP    = 1,
  parameter int         Y_GAP     = 12,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_tick,
  output logic [NUM_OBJ-1:0]   load_x,
  output logic [3:0]           rand_int,
  output logic [8*NUM_OBJ-1:0] y_all,
  output logic                 busy,
  output logic                 overrun,
  output logic [15:0]          spawn_count
);

  localparam int               IDX_W    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OBJ - 1);
  localparam logic [7:0]       Y_MAX_B  = 8'(Y_MAX);
  localparam logic [8:0]       Y_STEP_W = 9'(Y_STEP);
  localparam logic [NUM_OBJ-1:0] ONE_HOT0 = {{(NUM_OBJ-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_LOAD   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         y_q [NUM_OBJ];
  logic [7:0]         y_d [NUM_OBJ];
  logic [7:0]         lfsr_q, lfsr_d;
  logic [3:0]         rand_q, rand_d;
  logic [NUM_OBJ-1:0] load_x_q, load_x_d;
  logic               overrun_q, overrun_d;
  logic               cnt_inc;

  // Per-slot datapath: saturating advance, bottom detect, output packing.
  // The sum is taken at 9 bits so a large step cannot wrap before the clamp.
  logic [8:0]         y_sum [NUM_OBJ];
  logic [7:0]         y_sat [NUM_OBJ];
  logic [NUM_OBJ-1:0] expired;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBJ; gi++) begin : g_slot
      assign y_sum[gi]          = {1'b0, y_q[gi]} + Y_STEP_W;
      assign y_sat[gi]          = (y_sum[gi] >= {1'b0, Y_MAX_B}) ? Y_MAX_B : y_sum[gi][7:0];
      assign expired[gi]        = (y_q[gi] >= Y_MAX_B);
      assign y_all[8*gi +: 8]   = y_q[gi];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    y_d       = y_q;
    rand_d    = rand_q;
    load_x_d  = '0;
    overrun_d = overrun_q;
    cnt_inc   = 1'b0;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running every cycle.
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Ticks that land while a sequence is in flight are dropped, but remembered.
    if (frame_tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_tick && enable) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        for (int i = 0; i < NUM_OBJ; i++) begin
          y_d[i] = y_sat[i];
        end
        idx_d   = '0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (expired[idx_q]) begin
          // Column 15 is folded onto 0 so the index stays within 0..14.
          rand_d   = (lfsr_q[3:0] == 4'hF) ? 4'h0 : lfsr_q[3:0];
          load_x_d = ONE_HOT0 << idx_q;
          state_d  = ST_LOAD;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_LOAD: begin
        y_d[idx_q] = 8'd0;
        cnt_inc    = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      rand_q    <= 4'd0;
      load_x_q  <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        y_q[i] <= 8'(i * Y_GAP);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lfsr_q    <= lfsr_d;
      rand_q    <= rand_d;
      load_x_q  <= load_x_d;
      overrun_q <= overrun_d;
      y_q       <= y_d;
    end
  end

`ifdef SPAWN_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {15'd0, cnt_inc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign spawn_count = cnt_q;
`else
  logic unused_cnt_inc;
  assign unused_cnt_inc = cnt_inc;
  assign spawn_count    = 16'd0;
`endif

  assign load_x   = load_x_q;
  assign rand_int = rand_q;
  assign busy     = (state_q != ST_IDLE);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spawn_scheduler
//
// Two instances share the clock: dut uses the default parameters and is
// checked every cycle against a frame-level reference model; dut_f uses
// Y_STEP=120 so every slot expires on one tick, and is checked from a table
// of expected per-cycle outputs plus a reset-abort sequence.
// -----------------------------------------------------------------------------
module tb_spawn_scheduler;

  localparam int N     = 10;
  localparam int YMAX  = 120;
  localparam int YGAP  = 12;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst, en, tk;
  logic [9:0]  load_x;
  logic [3:0]  rand_int;
  logic [79:0] y_all;
  logic        busy, overrun;
  logic [15:0] spawn_count;

  // fast instance
  logic        rst_f, en_f, tk_f;
  logic [9:0]  load_x_f;
  logic [3:0]  rand_int_f;
  logic [79:0] y_all_f;
  logic        busy_f, overrun_f;
  logic [15:0] spawn_count_f;

  spawn_scheduler dut (
    .clk(clk), .reset(rst), .enable(en), .frame_tick(tk),
    .load_x(load_x), .rand_int(rand_int), .y_all(y_all),
    .busy(busy), .overrun(overrun), .spawn_count(spawn_count)
  );

  spawn_scheduler #(.Y_STEP(120)) dut_f (
    .clk(clk), .reset(rst_f), .enable(en_f), .frame_tick(tk_f),
    .load_x(load_x_f), .rand_int(rand_int_f), .y_all(y_all_f),
    .busy(busy_f), .overrun(overrun_f), .spawn_count(spawn_count_f)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct packed {
    logic [9:0]  load;
    logic        busy;
    logic [79:0] y;
    logic [15:0] cnt;
  } ent_t;

  int          m_y [N];
  logic [7:0]  m_lfsr, m_prev;
  logic        m_ov;
  int          m_cnt;
  ent_t        m_q[$];
  ent_t        cur;
  logic [7:0]  f_lfsr, f_prev;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [3:0] col_of(input logic [7:0] v);
    return (v[3:0] == 4'hF) ? 4'h0 : v[3:0];
  endfunction

  function automatic logic [79:0] pack_y();
    logic [79:0] r = '0;
    for (int i = 0; i < N; i++) r[8*i +: 8] = 8'(m_y[i]);
    return r;
  endfunction

  // On an accepted tick the whole busy sequence is known up front: one update
  // cycle, one scan per slot, and an extra load cycle after each expired slot.
  task automatic accept_tick(input int step);
    int c = m_cnt;
    m_q.push_back('{load: 10'd0, busy: 1'b1, y: pack_y(), cnt: 16'(c)});
    for (int i = 0; i < N; i++) m_y[i] = (m_y[i] + step > YMAX) ? YMAX : m_y[i] + step;
    for (int k = 0; k < N; k++) begin
      m_q.push_back('{load: 10'd0, busy: 1'b1, y: pack_y(), cnt: 16'(c)});
      if (m_y[k] >= YMAX) begin
        m_q.push_back('{load: 10'(1 << k), busy: 1'b1, y: pack_y(), cnt: 16'(c)});
        m_y[k] = 0;
        c++;
      end
    end
    m_cnt = c;
  endtask

  task automatic model_edge();
    logic was_busy;
    if (rst) begin
      for (int i = 0; i < N; i++) m_y[i] = i * YGAP;
      m_lfsr = 8'hA5; m_prev = 8'hA5;
      m_ov = 1'b0; m_cnt = 0;
      m_q.delete();
      cur = '{load: 10'd0, busy: 1'b0, y: pack_y(), cnt: 16'd0};
    end else begin
      m_prev   = m_lfsr;
      m_lfsr   = lfsr_step(m_lfsr);
      was_busy = cur.busy;
      if (tk && was_busy) m_ov = 1'b1;
      if (tk && !was_busy && en) accept_tick(1);
      if (m_q.size() > 0) cur = m_q.pop_front();
      else cur = '{load: 10'd0, busy: 1'b0, y: pack_y(), cnt: 16'(m_cnt)};
    end
    if (rst_f) begin
      f_lfsr = 8'hA5; f_prev = 8'hA5;
    end else begin
      f_prev = f_lfsr;
      f_lfsr = lfsr_step(f_lfsr);
    end
  endtask

  task automatic check_main();
    logic [15:0] exp_cnt;
`ifdef SPAWN_COUNT_EN
    exp_cnt = cur.cnt;
`else
    exp_cnt = 16'd0;
`endif
    chk("load_x",      80'(load_x),      80'(cur.load));
    chk("busy",        80'(busy),        80'(cur.busy));
    chk("y_all",       y_all,            cur.y);
    chk("overrun",     80'(overrun),     80'(m_ov));
    chk("spawn_count", 80'(spawn_count), 80'(exp_cnt));
    if (cur.load != 10'd0) chk("rand_int", 80'(rand_int), 80'(col_of(m_prev)));
  endtask

  // Inputs are changed 1 time unit after an edge; outputs checked there too.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_main();
  endtask

  // ---------------- fast-instance table ----------------
  typedef struct {
    logic       tick;
    logic [9:0] exp_load;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [23];

  initial begin
    int first_load;
    int nbusy;

    // offset 0 = update cycle, odd = scan of slot (j-1)/2, even = its load
    for (int j = 0; j < 23; j++) begin
      tbl[j].tick     = (j == 0);
      tbl[j].exp_busy = (j <= 20);
      tbl[j].exp_load = (j >= 2 && j <= 20 && (j % 2) == 0) ? 10'(1 << ((j - 2) / 2)) : 10'd0;
    end

    rst = 1'b1; en = 1'b0; tk = 1'b0;
    rst_f = 1'b1; en_f = 1'b0; tk_f = 1'b0;
    #2;
    step(); step();
    for (int i = 0; i < N; i++) chk("reset_stagger", 80'(y_all[8*i +: 8]), 80'(i * YGAP));
    rst = 1'b0; rst_f = 1'b0; en = 1'b1;
    for (int i = 0; i < 11; i++) step();

    // 12 ticks, 20 cycles apart; slot 9 reaches the bottom on tick 12
    first_load = -1;
    for (int n = 1; n <= 12; n++) begin
      tk = 1'b1; step(); tk = 1'b0;
      for (int j = 1; j < 20; j++) begin
        step();
        if (n == 12 && first_load < 0 && load_x != 10'd0) begin
          first_load = j;
          chk("tick12_load", 80'(load_x), 80'(10'h200));
          chk("tick12_rand_range", 80'(rand_int <= 4'd14), 80'(1'b1));
        end
        if (n == 12 && j == 12) chk("tick12_y9_cleared", 80'(y_all[79:72]), 80'd0);
      end
    end
    chk("tick12_latency", 80'(first_load), 80'(11));

    // second tick two cycles after an accepted one is dropped
    chk("overrun_before", 80'(overrun), 80'(1'b0));
    tk = 1'b1; step(); tk = 1'b0; step();
    tk = 1'b1; step(); tk = 1'b0;
    for (int j = 0; j < 30; j++) step();
    chk("overrun_sticky", 80'(overrun), 80'(1'b1));

    // enable low: ticks ignored, nothing moves
    rst = 1'b1; step(); rst = 1'b0; en = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tk = 1'b1; step(); tk = 1'b0;
      for (int j = 0; j < 5; j++) step();
    end
    for (int i = 0; i < N; i++) chk("disabled_y", 80'(y_all[8*i +: 8]), 80'(i * YGAP));

    // randomized traffic, including ticks while busy and stray resets
    for (int j = 0; j < 3000; j++) begin
      en  = ($urandom_range(3) != 0);
      tk  = ($urandom_range(7) == 0);
      rst = ($urandom_range(499) == 0);
      step();
    end
    rst = 1'b0; tk = 1'b0; en = 1'b1;

    // fast instance: every slot expires on one tick
    rst_f = 1'b1; step(); rst_f = 1'b0; en_f = 1'b1;
    nbusy = 0;
    for (int j = 0; j < 23; j++) begin
      tk_f = tbl[j].tick;
      step();
      tk_f = 1'b0;
      if (busy_f) nbusy++;
      chk("fast_load_x", 80'(load_x_f), 80'(tbl[j].exp_load));
      chk("fast_busy",   80'(busy_f),   80'(tbl[j].exp_busy));
      if (load_x_f != 10'd0) begin
        chk("fast_rand", 80'(rand_int_f), 80'(col_of(f_prev)));
        chk("fast_rand_range", 80'(rand_int_f <= 4'd14), 80'(1'b1));
      end
    end
    chk("fast_busy_cycles", 80'(nbusy), 80'(21));
    chk("fast_y_zero",      y_all_f,    80'd0);
    chk("fast_overrun",     80'(overrun_f), 80'(1'b0));
`ifdef SPAWN_COUNT_EN
    chk("fast_spawn_count", 80'(spawn_count_f), 80'(10));
`else
    chk("fast_spawn_count", 80'(spawn_count_f), 80'(0));
`endif

    // reset landing on the third load aborts the sequence
    rst_f = 1'b1; step(); rst_f = 1'b0;
    tk_f = 1'b1; step(); tk_f = 1'b0;
    for (int j = 1; j <= 6; j++) step();
    chk("abort_third_load", 80'(load_x_f), 80'(10'h004));
    rst_f = 1'b1; step(); rst_f = 1'b0;
    chk("abort_load_cleared", 80'(load_x_f), 80'd0);
    chk("abort_busy_cleared", 80'(busy_f),   80'd0);
    chk("abort_spawn_count",  80'(spawn_count_f), 80'd0);
    for (int i = 0; i < N; i++) chk("abort_stagger", 80'(y_all_f[8*i +: 8]), 80'(i * YGAP));
    for (int j = 0; j < 25; j++) begin
      step();
      chk("abort_no_strobe", 80'(load_x_f), 80'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
